// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between an instruction-fetch
// port (0) and a load/store port (1), with one outstanding read and a read watchdog.
module mem_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 15,
    localparam int unsigned PW     = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             p0_req_i,
    input  logic             p0_we_i,
    input  logic [PW-1:0]    p0_pos_i,
    input  logic [WIDTH-1:0] p0_wdata_i,
    output logic             p0_gnt_o,
    output logic [WIDTH-1:0] p0_rdata_o,
    output logic             p0_rvalid_o,
    output logic             p0_rerr_o,
    input  logic             p1_req_i,
    input  logic             p1_we_i,
    input  logic [PW-1:0]    p1_pos_i,
    input  logic [WIDTH-1:0] p1_wdata_i,
    output logic             p1_gnt_o,
    output logic [WIDTH-1:0] p1_rdata_o,
    output logic             p1_rvalid_o,
    output logic             p1_rerr_o,
    output logic             mem_read_en_o,
    output logic [PW-1:0]    mem_read_pos_o,
    input  logic [WIDTH-1:0] mem_read_data_i,
    input  logic             mem_read_valid_i,
    output logic             mem_write_en_o,
    output logic [PW-1:0]    mem_write_pos_o,
    output logic [WIDTH-1:0] mem_write_data_o
);

    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_RD = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic             prio_q, prio_d;
    logic             owner_q, owner_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [WIDTH-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
    logic             p0_rvalid_q, p0_rvalid_d, p1_rvalid_q, p1_rvalid_d;
    logic             p0_rerr_q, p0_rerr_d, p1_rerr_q, p1_rerr_d;

    logic             win;
    logic             win_we;
    logic [PW-1:0]    win_pos;
    logic [WIDTH-1:0] win_wdata;

    // State and response registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            owner_q     <= 1'b0;
            timer_q     <= '0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rerr_q   <= 1'b0;
            p1_rerr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            owner_q     <= owner_d;
            timer_q     <= timer_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
            p0_rerr_q   <= p0_rerr_d;
            p1_rerr_q   <= p1_rerr_d;
        end
    end

    // Arbitration, memory sequencing and read-return routing
    always_comb begin
        state_d          = state_q;
        prio_d           = prio_q;
        owner_d          = owner_q;
        timer_d          = timer_q;
        p0_rdata_d       = p0_rdata_q;
        p1_rdata_d       = p1_rdata_q;
        p0_rvalid_d      = 1'b0;
        p1_rvalid_d      = 1'b0;
        p0_rerr_d        = 1'b0;
        p1_rerr_d        = 1'b0;
        p0_gnt_o         = 1'b0;
        p1_gnt_o         = 1'b0;
        mem_read_en_o    = 1'b0;
        mem_read_pos_o   = '0;
        mem_write_en_o   = 1'b0;
        mem_write_pos_o  = '0;
        mem_write_data_o = '0;
        win              = (p0_req_i && p1_req_i) ? prio_q : p1_req_i;
        win_we           = win ? p1_we_i : p0_we_i;
        win_pos          = win ? p1_pos_i : p0_pos_i;
        win_wdata        = win ? p1_wdata_i : p0_wdata_i;

        case (state_q)
            IDLE: begin
                if (!rst_i && (p0_req_i || p1_req_i)) begin
                    p0_gnt_o = ~win;
                    p1_gnt_o = win;
                    prio_d   = ~win;
                    if (win_we) begin
                        mem_write_en_o   = 1'b1;
                        mem_write_pos_o  = win_pos;
                        mem_write_data_o = win_wdata;
                    end else begin
                        mem_read_en_o  = 1'b1;
                        mem_read_pos_o = win_pos;
                        state_d        = WAIT_RD;
                        owner_d        = win;
                        timer_d        = '0;
                    end
                end
            end
            WAIT_RD: begin
                timer_d = timer_q + TW'(1);
                if (mem_read_valid_i) begin
                    state_d = IDLE;
                    if (owner_q) begin
                        p1_rdata_d  = mem_read_data_i;
                        p1_rvalid_d = 1'b1;
                    end else begin
                        p0_rdata_d  = mem_read_data_i;
                        p0_rvalid_d = 1'b1;
                    end
                end else if (timer_q == TW'(TIMEOUT - 2)) begin
                    // Abort so the error pulse lands TIMEOUT cycles after the grant
                    state_d = IDLE;
                    if (owner_q) begin
                        p1_rdata_d  = '0;
                        p1_rvalid_d = 1'b1;
                        p1_rerr_d   = 1'b1;
                    end else begin
                        p0_rdata_d  = '0;
                        p0_rvalid_d = 1'b1;
                        p0_rerr_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign p0_rdata_o  = p0_rdata_q;
    assign p1_rdata_o  = p1_rdata_q;
    assign p0_rvalid_o = p0_rvalid_q;
    assign p1_rvalid_o = p1_rvalid_q;
    assign p0_rerr_o   = p0_rerr_q;
    assign p1_rerr_o   = p1_rerr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario-driven bench for mem_arbiter with a behavioural memory and a response scoreboard.
module tb_mem_arbiter;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned TIMEOUT = 15;
    localparam int unsigned PW      = 4;

    typedef logic [WIDTH:0] resp_t;  // {err, data}

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic             p0_req_i = 1'b0, p0_we_i = 1'b0, p1_req_i = 1'b0, p1_we_i = 1'b0;
    logic [PW-1:0]    p0_pos_i = '0, p1_pos_i = '0;
    logic [WIDTH-1:0] p0_wdata_i = '0, p1_wdata_i = '0;
    logic             p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o, p0_rerr_o, p1_rerr_o;
    logic [WIDTH-1:0] p0_rdata_o, p1_rdata_o;
    logic             mem_read_en_o, mem_write_en_o, mem_read_valid_i;
    logic [PW-1:0]    mem_read_pos_o, mem_write_pos_o;
    logic [WIDTH-1:0] mem_read_data_i, mem_write_data_o;

    int    n_tests = 0;
    int    n_fail  = 0;
    resp_t q0[$];
    resp_t q1[$];

    // Behavioural memory: programmable read latency, optional silence, injectable valid
    logic [WIDTH-1:0] tb_mem [DEPTH];
    int               lat    = 1;
    bit               mute   = 1'b0;
    logic             inject = 1'b0;
    bit               loaded = 1'b0;
    logic             mv     = 1'b0;
    logic [WIDTH-1:0] md     = '0;
    logic [WIDTH-1:0] pdata  = '0;
    bit               pend   = 1'b0;
    int               cnt    = 0;

    assign mem_read_valid_i = mv | inject;
    assign mem_read_data_i  = md;

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        mv <= 1'b0;
        if (!loaded) begin
            for (int i = 0; i < int'(DEPTH); i++) tb_mem[i] <= 32'h1000 + WIDTH'(i);
            loaded <= 1'b1;
        end
        if (mem_write_en_o) tb_mem[mem_write_pos_o] <= mem_write_data_o;
        if (pend) begin
            if (cnt == 0) begin
                mv   <= 1'b1;
                md   <= pdata;
                pend <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
        if (mem_read_en_o && !mute) begin
            if (lat <= 1) begin
                mv <= 1'b1;
                md <= tb_mem[mem_read_pos_o];
            end else begin
                pend  <= 1'b1;
                cnt   <= lat - 2;
                pdata <= tb_mem[mem_read_pos_o];
            end
        end
    end

    mem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p0_req_i(p0_req_i), .p0_we_i(p0_we_i), .p0_pos_i(p0_pos_i), .p0_wdata_i(p0_wdata_i),
        .p0_gnt_o(p0_gnt_o), .p0_rdata_o(p0_rdata_o), .p0_rvalid_o(p0_rvalid_o), .p0_rerr_o(p0_rerr_o),
        .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_pos_i(p1_pos_i), .p1_wdata_i(p1_wdata_i),
        .p1_gnt_o(p1_gnt_o), .p1_rdata_o(p1_rdata_o), .p1_rvalid_o(p1_rvalid_o), .p1_rerr_o(p1_rerr_o),
        .mem_read_en_o(mem_read_en_o), .mem_read_pos_o(mem_read_pos_o),
        .mem_read_data_i(mem_read_data_i), .mem_read_valid_i(mem_read_valid_i),
        .mem_write_en_o(mem_write_en_o), .mem_write_pos_o(mem_write_pos_o),
        .mem_write_data_o(mem_write_data_o)
    );

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs;
        p0_req_i = 1'b0; p0_we_i = 1'b0; p0_pos_i = '0; p0_wdata_i = '0;
        p1_req_i = 1'b0; p1_we_i = 1'b0; p1_pos_i = '0; p1_wdata_i = '0;
        inject   = 1'b0;
    endtask

    task automatic do_reset;
        step;
        rst_i = 1'b1;
        idle_inputs;
        step;
        rst_i = 1'b0;
    endtask

    task automatic test_reset;
        step;
        rst_i = 1'b1;
        p0_req_i = 1'b1; p0_we_i = 1'b1; p1_req_i = 1'b1;
        #1;
        n_tests++;
        if ({p0_gnt_o, p1_gnt_o, mem_write_en_o, mem_read_en_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_comb: got %b expected 0000", {p0_gnt_o, p1_gnt_o, mem_write_en_o, mem_read_en_o});
        end
        step;
        n_tests++;
        if ({p0_rdata_o, p1_rdata_o, p0_rvalid_o, p1_rvalid_o, p0_rerr_o, p1_rerr_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: got %h/%h %b%b%b%b expected all zero",
                     p0_rdata_o, p1_rdata_o, p0_rvalid_o, p1_rvalid_o, p0_rerr_o, p1_rerr_o);
        end
        idle_inputs;
        rst_i = 1'b0;
        step;
        inject = 1'b1;
        step;
        inject = 1'b0;
        #1;
        n_tests++;
        if ({p0_rvalid_o, p1_rvalid_o, p0_rdata_o} !== {2'b00, 32'h0}) begin
            n_fail++;
            $display("FAIL spurious_valid: got rvalid %b%b rdata %h expected 00 / 0", p0_rvalid_o, p1_rvalid_o, p0_rdata_o);
        end
    endtask

    task automatic test_write_read;
        resp_t r;
        step;
        p0_req_i = 1'b1; p0_we_i = 1'b1; p0_pos_i = 4'd5; p0_wdata_i = 32'd69;
        #1;
        n_tests++;
        if ({p0_gnt_o, p1_gnt_o, mem_write_en_o, mem_read_en_o, mem_write_pos_o, mem_write_data_o}
            !== {4'b1010, 4'd5, 32'd69}) begin
            n_fail++;
            $display("FAIL wr_grant: got gnt %b%b we %b re %b pos %0d data %0d expected 1 0 1 0 5 69",
                     p0_gnt_o, p1_gnt_o, mem_write_en_o, mem_read_en_o, mem_write_pos_o, mem_write_data_o);
        end
        step;
        p0_we_i = 1'b0; p0_wdata_i = '0;
        #1;
        n_tests++;
        if ({p0_gnt_o, mem_read_en_o, mem_read_pos_o, mem_write_en_o} !== {2'b11, 4'd5, 1'b0}) begin
            n_fail++;
            $display("FAIL rd_grant: got gnt %b re %b pos %0d we %b expected 1 1 5 0",
                     p0_gnt_o, mem_read_en_o, mem_read_pos_o, mem_write_en_o);
        end
        q0.push_back({1'b0, 32'd69});
        step;
        idle_inputs;
        #1;
        n_tests++;
        if ({p0_rvalid_o, p0_gnt_o, mem_read_en_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL rd_wait: got rvalid %b gnt %b re %b expected 000", p0_rvalid_o, p0_gnt_o, mem_read_en_o);
        end
        step;
        n_tests++;
        if ({p0_rvalid_o, p1_rvalid_o} !== 2'b10 || q0.size() == 0) begin
            n_fail++;
            $display("FAIL rd_latency: got rvalid %b%b expected 10", p0_rvalid_o, p1_rvalid_o);
        end else begin
            r = q0.pop_front();
            n_tests++;
            if ({p0_rerr_o, p0_rdata_o} !== r) begin
                n_fail++;
                $display("FAIL rd_data: got err %b data %0d expected err %b data %0d", p0_rerr_o, p0_rdata_o, r[WIDTH], r[WIDTH-1:0]);
            end
        end
    endtask

    task automatic test_simul_writes;
        do_reset;
        p0_req_i = 1'b1; p0_we_i = 1'b1; p0_pos_i = 4'd1; p0_wdata_i = 32'hA;
        p1_req_i = 1'b1; p1_we_i = 1'b1; p1_pos_i = 4'd2; p1_wdata_i = 32'hB;
        #1;
        n_tests++;
        if ({p0_gnt_o, p1_gnt_o, mem_write_en_o, mem_write_pos_o, mem_write_data_o} !== {3'b101, 4'd1, 32'hA}) begin
            n_fail++;
            $display("FAIL simul_first: got gnt %b%b we %b pos %0d data %h expected 10 1 1 a",
                     p0_gnt_o, p1_gnt_o, mem_write_en_o, mem_write_pos_o, mem_write_data_o);
        end
        step;
        p0_req_i = 1'b0;
        #1;
        n_tests++;
        if ({p0_gnt_o, p1_gnt_o, mem_write_en_o, mem_write_pos_o, mem_write_data_o} !== {3'b011, 4'd2, 32'hB}) begin
            n_fail++;
            $display("FAIL simul_second: got gnt %b%b we %b pos %0d data %h expected 01 1 2 b",
                     p0_gnt_o, p1_gnt_o, mem_write_en_o, mem_write_pos_o, mem_write_data_o);
        end
        step;
        idle_inputs;
        step;
        n_tests++;
        if ({tb_mem[1], tb_mem[2]} !== {32'hA, 32'hB}) begin
            n_fail++;
            $display("FAIL simul_mem: got %h %h expected a b", tb_mem[1], tb_mem[2]);
        end
    endtask

    task automatic test_fairness;
        resp_t r;
        int    grants;
        logic  exp_port;
        grants   = 0;
        exp_port = 1'b0;
        do_reset;
        p0_req_i = 1'b1; p0_pos_i = 4'd3;
        p1_req_i = 1'b1; p1_pos_i = 4'd7;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (p0_gnt_o && p1_gnt_o) begin
                n_tests++; n_fail++;
                $display("FAIL fair_double: got both grants expected one");
            end else if (p0_gnt_o || p1_gnt_o) begin
                n_tests++;
                if (p1_gnt_o !== exp_port) begin
                    n_fail++;
                    $display("FAIL fair_order: grant %0d got port %b expected %b", grants, p1_gnt_o, exp_port);
                end
                if (p1_gnt_o) q1.push_back({1'b0, 32'h1007});
                else          q0.push_back({1'b0, 32'h1003});
                grants++;
                exp_port = ~exp_port;
            end
            if (p0_rvalid_o) begin
                n_tests++;
                if (q0.size() == 0) begin
                    n_fail++;
                    $display("FAIL fair_stray0: got rvalid 1 expected 0");
                end else begin
                    r = q0.pop_front();
                    if ({p0_rerr_o, p0_rdata_o} !== r) begin
                        n_fail++;
                        $display("FAIL fair_data0: got %h expected %h", {p0_rerr_o, p0_rdata_o}, r);
                    end
                end
            end
            if (p1_rvalid_o) begin
                n_tests++;
                if (q1.size() == 0) begin
                    n_fail++;
                    $display("FAIL fair_stray1: got rvalid 1 expected 0");
                end else begin
                    r = q1.pop_front();
                    if ({p1_rerr_o, p1_rdata_o} !== r) begin
                        n_fail++;
                        $display("FAIL fair_data1: got %h expected %h", {p1_rerr_o, p1_rdata_o}, r);
                    end
                end
            end
            if (grants >= 4 && q0.size() == 0 && q1.size() == 0) break;
            step;
            if (grants >= 4) idle_inputs;
        end
        n_tests++;
        if (grants != 4 || q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL fair_budget: got %0d grants, %0d/%0d pending expected 4 grants, 0/0 pending",
                     grants, q0.size(), q1.size());
        end
        step;
        idle_inputs;
    endtask

    task automatic test_back_to_back_block;
        resp_t r;
        int    cyc;
        bit    seen;
        cyc  = 0;
        seen = 1'b0;
        do_reset;
        lat = 3;
        p1_req_i = 1'b1; p1_we_i = 1'b0; p1_pos_i = 4'd4;
        #1;
        n_tests++;
        if ({p0_gnt_o, p1_gnt_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL blk_grant: got %b%b expected 01", p0_gnt_o, p1_gnt_o);
        end
        q1.push_back({1'b0, 32'h1004});
        step;
        p1_req_i = 1'b0;
        p0_req_i = 1'b1; p0_we_i = 1'b1; p0_pos_i = 4'd9; p0_wdata_i = 32'h99;
        for (int c = 0; c < 10; c++) begin
            #1;
            cyc++;
            n_tests++;
            if (p1_rvalid_o) begin
                if ({p0_gnt_o, mem_write_en_o, mem_write_pos_o, mem_write_data_o} !== {2'b11, 4'd9, 32'h99} || cyc != 4) begin
                    n_fail++;
                    $display("FAIL blk_release: got gnt %b we %b cyc %0d expected 1 1 4", p0_gnt_o, mem_write_en_o, cyc);
                end
                n_tests++;
                if (q1.size() == 0) begin
                    n_fail++;
                    $display("FAIL blk_stray: got rvalid 1 with nothing outstanding expected 0");
                end else begin
                    r = q1.pop_front();
                    if ({p1_rerr_o, p1_rdata_o} !== r) begin
                        n_fail++;
                        $display("FAIL blk_data: got %h expected %h", {p1_rerr_o, p1_rdata_o}, r);
                    end
                end
                seen = 1'b1;
                break;
            end else if (p0_gnt_o || mem_write_en_o) begin
                n_fail++;
                $display("FAIL blk_hold: cycle %0d got gnt %b we %b expected 0 0", cyc, p0_gnt_o, mem_write_en_o);
            end
            step;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL blk_budget: got no p1 response expected one within 10 cycles");
        end
        step;
        idle_inputs;
        lat = 1;
    endtask

    task automatic test_timeout;
        resp_t r;
        int    cyc;
        bit    seen;
        cyc  = 0;
        seen = 1'b0;
        do_reset;
        mute = 1'b1;
        p1_req_i = 1'b1; p1_pos_i = 4'd6;
        #1;
        n_tests++;
        if (p1_gnt_o !== 1'b1) begin
            n_fail++;
            $display("FAIL to_grant: got %b expected 1", p1_gnt_o);
        end
        q1.push_back({1'b1, 32'h0});
        for (int c = 0; c < 40; c++) begin
            step;
            if (c == 0) idle_inputs;
            #1;
            cyc++;
            if (p1_rvalid_o || p0_rvalid_o) begin
                n_tests++;
                if (!p1_rvalid_o || p0_rvalid_o || cyc != int'(TIMEOUT)) begin
                    n_fail++;
                    $display("FAIL to_latency: got rvalid %b%b at cycle %0d expected 01 at %0d",
                             p0_rvalid_o, p1_rvalid_o, cyc, TIMEOUT);
                end
                n_tests++;
                if (q1.size() == 0) begin
                    n_fail++;
                    $display("FAIL to_stray: got rvalid 1 with nothing outstanding expected 0");
                end else begin
                    r = q1.pop_front();
                    if ({p1_rerr_o, p1_rdata_o} !== r) begin
                        n_fail++;
                        $display("FAIL to_resp: got err %b data %h expected err %b data %h",
                                 p1_rerr_o, p1_rdata_o, r[WIDTH], r[WIDTH-1:0]);
                    end
                end
                p0_req_i = 1'b1; p0_we_i = 1'b1; p0_pos_i = 4'd0; p0_wdata_i = 32'h1;
                #1;
                n_tests++;
                if ({p0_gnt_o, mem_write_en_o} !== 2'b11) begin
                    n_fail++;
                    $display("FAIL to_idle: got gnt %b we %b expected 1 1", p0_gnt_o, mem_write_en_o);
                end
                seen = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL to_budget: got no response expected one within 40 cycles");
        end
        step;
        idle_inputs;
        mute = 1'b0;
    endtask

    task automatic test_reset_mid_read;
        do_reset;
        mute = 1'b1;
        p0_req_i = 1'b1; p0_pos_i = 4'd3;
        #1;
        n_tests++;
        if (p0_gnt_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rmr_grant: got %b expected 1", p0_gnt_o);
        end
        step;
        idle_inputs;
        rst_i = 1'b1;
        step;
        rst_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            inject = (c == 1);
            #1;
            n_tests++;
            if ({p0_rvalid_o, p1_rvalid_o, p0_gnt_o, p1_gnt_o} !== 4'b0000) begin
                n_fail++;
                $display("FAIL rmr_quiet: cycle %0d got rvalid %b%b gnt %b%b expected 0000",
                         c, p0_rvalid_o, p1_rvalid_o, p0_gnt_o, p1_gnt_o);
            end
            step;
        end
        inject   = 1'b0;
        p0_req_i = 1'b1; p0_we_i = 1'b1; p0_pos_i = 4'd10; p0_wdata_i = 32'h10;
        p1_req_i = 1'b1; p1_we_i = 1'b1; p1_pos_i = 4'd11; p1_wdata_i = 32'h11;
        #1;
        n_tests++;
        if ({p0_gnt_o, p1_gnt_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL rmr_prio: got %b%b expected 10", p0_gnt_o, p1_gnt_o);
        end
        step;
        idle_inputs;
        mute = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs;
        test_reset;
        test_write_read;
        test_simul_writes;
        test_fairness;
        test_back_to_back_block;
        test_timeout;
        test_reset_mid_read;
        n_tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
